// File: rtl/prom_param_reader_if.sv
// prom_param_reader_if: start/PROM pads/parameter write port of the PROM parameter reader
interface prom_param_reader_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
);
  logic              start;
  logic [DATA_W-1:0] param_dat;
  logic              param_ce_b;
  logic              param_oe;
  logic              param_clk_en;
  logic [DATA_W-1:0] word;
  logic [AW-1:0]     waddr;
  logic              we;
  logic              busy;
  logic              done;
  logic              err;
  modport master (output start, param_dat,
                  input  param_ce_b, param_oe, param_clk_en, word, waddr, we, busy, done, err);
  modport slave  (input  start, param_dat,
                  output param_ce_b, param_oe, param_clk_en, word, waddr, we, busy, done, err);
endinterface

// File: rtl/prom_param_reader.sv
// prom_param_reader: sequenced bounded block read of the parallel parameter PROM.
// Define PROM_XFER_CKSUM_EN to treat the last word as a checksum and flag ERR on a nonzero sum.
module prom_param_reader #(
  parameter int DATA_W    = 8,
  parameter int NWORDS    = 16,
  parameter int RST_CYC   = 4,
  parameter int FIRST_LAT = 2,
  parameter int AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input logic clk,
  input logic rst,
  prom_param_reader_if.slave s
);
  typedef enum logic [2:0] {IDLE, ADDR_RST, PRIME, READ, FINISH} state_t;
  localparam logic [15:0] RC  = 16'(RST_CYC);
  localparam logic [15:0] FL1 = 16'(FIRST_LAT - 1);
  localparam logic [15:0] NW  = 16'(NWORDS);
  localparam logic [15:0] NW1 = 16'(NWORDS - 1);
  state_t            state;
  logic [15:0]       cnt;
  logic [DATA_W-1:0] din;
  logic              cap;
  // din is the IOB capture flop; cap marks that din holds a block word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      din            <= '0;
      cap            <= 1'b0;
      s.param_ce_b   <= 1'b1;
      s.param_oe     <= 1'b0;
      s.param_clk_en <= 1'b0;
      s.word         <= '0;
      s.waddr        <= '0;
      s.we           <= 1'b0;
      s.busy         <= 1'b0;
      s.done         <= 1'b0;
    end else begin
      din  <= s.param_dat;
      cap  <= 1'b0;
      s.we <= cap;
      if (cap) begin
        s.word  <= din;
        s.waddr <= s.we ? s.waddr + 1'b1 : s.waddr;
      end
      case (state)
        IDLE:
          if (s.start) begin
            state  <= ADDR_RST;
            s.busy <= 1'b1;
            cnt    <= '0;
          end
        ADDR_RST: begin
          s.param_ce_b <= 1'b0;
          cnt          <= cnt + 16'd1;
          if (cnt == RC) begin
            state          <= PRIME;
            s.param_oe     <= 1'b1;
            s.param_clk_en <= 1'b1;
            cnt            <= '0;
          end
        end
        PRIME: begin
          cnt <= cnt + 16'd1;
          if (cnt == FL1) begin
            state <= READ;
            cap   <= 1'b1;
            cnt   <= 16'd1;
            if (NW1 == 16'd0) {s.param_ce_b, s.param_oe, s.param_clk_en} <= 3'b100;
          end
        end
        READ:
          if (cnt == NW) state <= FINISH;
          else begin
            cap <= 1'b1;
            cnt <= cnt + 16'd1;
            if (cnt == NW1) {s.param_ce_b, s.param_oe, s.param_clk_en} <= 3'b100;
          end
        FINISH:
          if (!s.done) begin
            s.done  <= 1'b1;
            s.waddr <= '0;
          end else begin
            s.done <= 1'b0;
            s.busy <= 1'b0;
            state  <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef PROM_XFER_CKSUM_EN
  logic [DATA_W-1:0] sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum   <= '0;
      s.err <= 1'b0;
    end else if (state == IDLE && s.start) begin
      sum   <= '0;
      s.err <= 1'b0;
    end else begin
      if (cap) sum <= sum + din;
      if (state == FINISH && !s.done) s.err <= |sum;
    end
`else
  assign s.err = 1'b0;
`endif
endmodule

// File: tb/tb_prom_param_reader.sv
// tb_prom_param_reader: directed checks of the PROM reader at default and minimal parameters
module tb_prom_param_reader;
  logic clk, rst;
  int n_chk, n_pass;
  int wcnt, dcnt, k0, k1, idx0;
  logic [7:0] mem [16];
`ifdef PROM_XFER_CKSUM_EN
  localparam logic [7:0] U1_W = 8'h00;
`else
  localparam logic [7:0] U1_W = 8'hA5;
`endif

  prom_param_reader_if #(.DATA_W(8), .AW(4)) i0 ();
  prom_param_reader_if #(.DATA_W(8), .AW(1)) i1 ();

  prom_param_reader u0 (.clk(clk), .rst(rst), .s(i0.slave));
  prom_param_reader #(.NWORDS(1), .RST_CYC(1), .FIRST_LAT(1), .AW(1)) u1 (.clk(clk), .rst(rst), .s(i1.slave));

  initial clk = 1'b0;
  always #25 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) begin
      k0 <= 0;
      k1 <= 0;
    end else begin
      k0 <= i0.param_oe ? k0 + 1 : 0;
      k1 <= i1.param_oe ? k1 + 1 : 0;
    end

  always_comb begin
    idx0 = k0 - 1;
    i0.param_dat = (i0.param_oe && idx0 >= 0 && idx0 < 16) ? mem[idx0[3:0]] : 8'hEE;
    i1.param_dat = (i1.param_oe && k1 == 0) ? U1_W : 8'hEE;
  end

  always @(posedge clk) begin
    if (i0.we) wcnt++;
    if (i0.done) dcnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse0();
    i0.start = 1'b1;
    tick(1);
    i0.start = 1'b0;
  endtask

  task automatic run(input logic exp_err, input bit inject);
    int w0, d0;
    pulse0();
    chk("busy_t0", i0.busy, 1);
    chk("ceb_t0", i0.param_ce_b, 1);
    chk("err_clr_t0", i0.err, 0);
    tick(1);
    chk("ceb_t1", i0.param_ce_b, 0);
    chk("oe_t1", i0.param_oe, 0);
    tick(3);
    chk("oe_t4", i0.param_oe, 0);
    tick(1);
    chk("oe_t5", i0.param_oe, 1);
    chk("clken_t5", i0.param_clk_en, 1);
    tick(2);
    chk("we_t7", i0.we, 0);
    w0 = wcnt;
    d0 = dcnt;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("we", i0.we, 1);
      chk("waddr", i0.waddr, i);
      chk("word", i0.word, mem[i]);
      if (inject && i == 1) i0.start = 1'b1;
      if (inject && i == 2) i0.start = 1'b0;
    end
    tick(1);
    chk("done_t24", i0.done, 1);
    chk("we_t24", i0.we, 0);
    chk("ceb_t24", i0.param_ce_b, 1);
    chk("busy_t24", i0.busy, 1);
    chk("err_t24", i0.err, exp_err);
    if (inject) i0.start = 1'b1;
    tick(1);
    i0.start = 1'b0;
    chk("done_t25", i0.done, 0);
    chk("busy_t25", i0.busy, 0);
    chk("err_held", i0.err, exp_err);
    tick(3);
    chk("no_restart_busy", i0.busy, 0);
    chk("no_restart_ceb", i0.param_ce_b, 1);
    chk("we_pulses", wcnt - w0, 16);
    chk("done_pulses", dcnt - d0, 1);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    wcnt = 0;
    dcnt = 0;
    rst = 1'b1;
    i0.start = 1'b0;
    i1.start = 1'b0;
    for (int i = 0; i < 16; i++)
`ifdef PROM_XFER_CKSUM_EN
      mem[i] = (i == 15) ? 8'h88 : 8'(i + 1);
`else
      mem[i] = 8'(8'h10 + i);
`endif
    tick(2);
    chk("rst_ceb", i0.param_ce_b, 1);
    chk("rst_oe", i0.param_oe, 0);
    chk("rst_clken", i0.param_clk_en, 0);
    chk("rst_word", i0.word, 0);
    chk("rst_waddr", i0.waddr, 0);
    chk("rst_we", i0.we, 0);
    chk("rst_busy", i0.busy, 0);
    chk("rst_done", i0.done, 0);
    chk("rst_err", i0.err, 0);
    rst = 1'b0;
    tick(2);
    run(1'b0, 1'b1);
`ifdef PROM_XFER_CKSUM_EN
    mem[15] = 8'h87;
    run(1'b1, 1'b0);
    tick(5);
    chk("err_still_held", i0.err, 1);
    mem[15] = 8'h88;
`endif
    pulse0();
    chk("abort_err_clr", i0.err, 0);
    tick(12);
    chk("abort_we_t12", i0.we, 1);
    rst = 1'b1;
    #1;
    chk("abort_ceb", i0.param_ce_b, 1);
    chk("abort_oe", i0.param_oe, 0);
    chk("abort_clken", i0.param_clk_en, 0);
    chk("abort_we", i0.we, 0);
    chk("abort_busy", i0.busy, 0);
    chk("abort_waddr", i0.waddr, 0);
    chk("abort_word", i0.word, 0);
    begin
      int d1;
      d1 = dcnt;
      tick(2);
      rst = 1'b0;
      tick(20);
      chk("abort_no_done", dcnt - d1, 0);
    end
    run(1'b0, 1'b0);
    i1.start = 1'b1;
    tick(1);
    i1.start = 1'b0;
    chk("n1_busy_t0", i1.busy, 1);
    tick(1);
    chk("n1_ceb_t1", i1.param_ce_b, 0);
    tick(1);
    chk("n1_oe_t2", i1.param_oe, 1);
    tick(1);
    chk("n1_we_t3", i1.we, 0);
    tick(1);
    chk("n1_we_t4", i1.we, 1);
    chk("n1_waddr", i1.waddr, 0);
    chk("n1_word", i1.word, U1_W);
    chk("n1_ceb_t4", i1.param_ce_b, 1);
    tick(1);
    chk("n1_done_t5", i1.done, 1);
    chk("n1_we_t5", i1.we, 0);
    chk("n1_err", i1.err, 0);
    tick(1);
    chk("n1_done_t6", i1.done, 0);
    chk("n1_busy_t6", i1.busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
